// File: rtl/serial_loader.sv
// UART boot loader: 8N1 receiver feeding a length-prefixed image into instruction memory as packed words.
// Latency: byte valid 1 cycle after stop sample, write strobe 1 cycle later; no backpressure, memory must accept every strobe.
module serial_loader #(
    parameter int WAIT_DIV    = 434,
    parameter int WORD_BYTES  = 4,
    parameter int LEN_BYTES   = 4,
    parameter int ADDR_W      = 14,
    parameter int CHECKSUM_EN = 1
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    rxd,
    output logic                    Rdata_valid,
    output logic [7:0]              receive_data,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    Receive_fin,
    output logic                    frame_err,
    output logic                    cksum_err
);

    localparam logic [31:0] HALF_TICKS = 32'(WAIT_DIV / 2 - 1);
    localparam logic [31:0] FULL_TICKS = 32'(WAIT_DIV - 1);
    localparam logic [31:0] LAST_HDR   = 32'(LEN_BYTES - 1);
    localparam logic [31:0] LAST_LANE  = 32'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        B_IDLE,
        B_START,
        B_DATA,
        B_STOP,
        B_WAIT_HIGH
    } bit_state_t;

    typedef enum logic [1:0] {
        S_LEN,
        S_DATA,
        S_CKSUM,
        S_FIN
    } load_state_t;

    // ------------------------------------------------------------------
    // Line synchroniser and bit engine
    // ------------------------------------------------------------------
    logic [2:0]  rx_sync;
    logic        rx_s;
    bit_state_t  bit_state;
    logic [31:0] bit_tmr;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        ferr_pulse;

    assign rx_s = rx_sync[2];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_sync <= 3'b111;
        end else begin
            rx_sync <= {rx_sync[1:0], rxd};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bit_state    <= B_IDLE;
            bit_tmr      <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            Rdata_valid  <= 1'b0;
            receive_data <= '0;
            frame_err    <= 1'b0;
            ferr_pulse   <= 1'b0;
        end else begin
            Rdata_valid <= 1'b0;
            ferr_pulse  <= 1'b0;
            case (bit_state)
                B_IDLE: begin
                    bit_tmr <= '0;
                    if (!rx_s) begin
                        bit_state <= B_START;
                    end
                end
                B_START: begin
                    if (bit_tmr == HALF_TICKS) begin
                        bit_tmr <= '0;
                        bit_idx <= '0;
                        // A line that is high again mid start bit was a glitch.
                        bit_state <= rx_s ? B_IDLE : B_DATA;
                    end else begin
                        bit_tmr <= bit_tmr + 32'd1;
                    end
                end
                B_DATA: begin
                    if (bit_tmr == FULL_TICKS) begin
                        bit_tmr <= '0;
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            bit_state <= B_STOP;
                        end
                    end else begin
                        bit_tmr <= bit_tmr + 32'd1;
                    end
                end
                B_STOP: begin
                    if (bit_tmr == FULL_TICKS) begin
                        bit_tmr <= '0;
                        if (rx_s) begin
                            Rdata_valid  <= 1'b1;
                            receive_data <= shreg;
                            bit_state    <= B_IDLE;
                        end else begin
                            frame_err  <= 1'b1;
                            ferr_pulse <= 1'b1;
                            bit_state  <= B_WAIT_HIGH;
                        end
                    end else begin
                        bit_tmr <= bit_tmr + 32'd1;
                    end
                end
                B_WAIT_HIGH: begin
                    if (rx_s) begin
                        bit_state <= B_IDLE;
                    end
                end
                default: bit_state <= B_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    load_state_t             load_state;
    logic [31:0]             hdr_cnt;
    logic [31:0]             byte_cnt;
    logic [31:0]             len;
    logic [7:0]              sum;
    logic [8*WORD_BYTES-1:0] word_buf;
    logic [ADDR_W-1:0]       word_idx;

    logic [31:0]             len_next;
    logic [31:0]             lane;
    logic [8*WORD_BYTES-1:0] word_next;
    logic                    last_byte;
    logic                    lane_full;

    always_comb begin
        len_next  = len | (32'(receive_data) << {hdr_cnt[1:0], 3'b000});
        lane      = byte_cnt % 32'(WORD_BYTES);
        last_byte = (byte_cnt == len - 32'd1);
        lane_full = (lane == LAST_LANE);
        word_next = word_buf;
        for (int l = 0; l < WORD_BYTES; l++) begin
            if (lane == 32'(l)) begin
                word_next[8*l +: 8] = receive_data;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            load_state  <= S_LEN;
            hdr_cnt     <= '0;
            byte_cnt    <= '0;
            len         <= '0;
            sum         <= '0;
            word_buf    <= '0;
            word_idx    <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            Receive_fin <= 1'b0;
            cksum_err   <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (ferr_pulse && load_state != S_FIN) begin
                // Abort: any partly filled word is simply never written.
                load_state  <= S_FIN;
                Receive_fin <= 1'b1;
            end else if (Rdata_valid) begin
                case (load_state)
                    S_LEN: begin
                        len <= len_next;
                        if (hdr_cnt == LAST_HDR) begin
                            hdr_cnt  <= '0;
                            byte_cnt <= '0;
                            if (len_next != 32'd0) begin
                                load_state <= S_DATA;
                            end else if (CHECKSUM_EN != 0) begin
                                load_state <= S_CKSUM;
                            end else begin
                                load_state  <= S_FIN;
                                Receive_fin <= 1'b1;
                            end
                        end else begin
                            hdr_cnt <= hdr_cnt + 32'd1;
                        end
                    end
                    S_DATA: begin
                        sum      <= sum + receive_data;
                        byte_cnt <= byte_cnt + 32'd1;
                        if (lane_full || last_byte) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= word_idx;
                            mem_wdata <= word_next;
                            word_idx  <= word_idx + 1'b1;
                            word_buf  <= '0;
                        end else begin
                            word_buf <= word_next;
                        end
                        if (last_byte) begin
                            if (CHECKSUM_EN != 0) begin
                                load_state <= S_CKSUM;
                            end else begin
                                load_state  <= S_FIN;
                                Receive_fin <= 1'b1;
                            end
                        end
                    end
                    S_CKSUM: begin
                        if (receive_data != sum) begin
                            cksum_err <= 1'b1;
                        end
                        load_state  <= S_FIN;
                        Receive_fin <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_serial_loader.sv
// Directed bench for serial_loader: table of whole frames plus glitch, mid-frame reset and no-checksum timing sequences.
`timescale 1ns/1ps
module tb_serial_loader;

    localparam int WD = 16;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        rxd = 1'b1;
    logic        rxd_b = 1'b1;

    logic        Rdata_valid, mem_we, Receive_fin, frame_err, cksum_err;
    logic [7:0]  receive_data;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;

    logic        Rdata_valid_b, mem_we_b, Receive_fin_b, frame_err_b, cksum_err_b;
    logic [7:0]  receive_data_b;
    logic [13:0] mem_addr_b;
    logic [31:0] mem_wdata_b;

    always #5 CLK = ~CLK;

    serial_loader #(.WAIT_DIV(WD), .WORD_BYTES(4), .LEN_BYTES(4), .ADDR_W(14), .CHECKSUM_EN(1)) u_dut (
        .CLK(CLK), .RST_N(RST_N), .rxd(rxd),
        .Rdata_valid(Rdata_valid), .receive_data(receive_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .Receive_fin(Receive_fin), .frame_err(frame_err), .cksum_err(cksum_err)
    );

    serial_loader #(.WAIT_DIV(WD), .WORD_BYTES(4), .LEN_BYTES(4), .ADDR_W(14), .CHECKSUM_EN(0)) u_nock (
        .CLK(CLK), .RST_N(RST_N), .rxd(rxd_b),
        .Rdata_valid(Rdata_valid_b), .receive_data(receive_data_b),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .Receive_fin(Receive_fin_b), .frame_err(frame_err_b), .cksum_err(cksum_err_b)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [13:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          rv_cnt;
    int          wr_cnt_b;
    int          rv_cyc_b;
    int          fin_cyc_b;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
        if (Rdata_valid) rv_cnt++;
        if (mem_we_b) wr_cnt_b++;
        if (Rdata_valid_b) rv_cyc_b = cyc;
        if (Receive_fin_b && fin_cyc_b < 0) fin_cyc_b = cyc;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic set_line(input bit b, input logic v);
        if (b) rxd_b = v;
        else rxd = v;
    endtask

    task automatic send_byte(input bit b, input logic [7:0] d, input bit stop_ok);
        set_line(b, 1'b0);
        tick(WD);
        for (int i = 0; i < 8; i++) begin
            set_line(b, d[i]);
            tick(WD);
        end
        set_line(b, stop_ok);
        tick(WD);
        set_line(b, 1'b1);
        tick(stop_ok ? WD / 2 : WD + WD / 2);
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        rv_cnt    = 0;
        wr_cnt_b  = 0;
        rv_cyc_b  = -1;
        fin_cyc_b = -1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        rxd   = 1'b1;
        rxd_b = 1'b1;
        tick(4);
        clear_mon();
        RST_N = 1'b1;
        tick(4);
    endtask

    task automatic wait_fin(input string name, input int limit);
        int n = 0;
        while (!Receive_fin && n < limit) begin
            tick(1);
            n++;
        end
        chk(name, Receive_fin, 1'b1);
    endtask

    task automatic chk_writes(input string tag, input int nwr, input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] exp_w;
        chk({tag, "_wr_count"}, wr_data.size(), nwr);
        for (int j = 0; j < nwr && j < wr_data.size(); j++) begin
            exp_w = (j == 0) ? w0 : w1;
            chk($sformatf("%s_wr%0d_addr", tag, j), wr_addr[j], j);
            chk($sformatf("%s_wr%0d_data", tag, j), wr_data[j], exp_w);
        end
    endtask

    typedef struct {
        string       name;
        int          len;
        logic [7:0]  pay[8];
        logic [7:0]  ck;
        int          bad_idx;
        int          nwr;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        ck_err;
        logic        fr_err;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"len8", 8, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 8'h24, -1, 2,
                    32'h04030201, 32'h08070605, 1'b0, 1'b0};
        vecs[1] = '{"len5", 5, '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'h00, 8'h00, 8'h00}, 8'h00, -1, 2,
                    32'hDDCCBBAA, 32'h000000EE, 1'b1, 1'b0};
        vecs[2] = '{"len0", 0, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 8'h00, -1, 0,
                    32'h0, 32'h0, 1'b0, 1'b0};
        vecs[3] = '{"ferr", 8, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 8'h24, 2, 0,
                    32'h0, 32'h0, 1'b0, 1'b1};
        clear_mon();
        tick(3);

        for (int v = 0; v < 4; v++) begin
            do_reset();
            chk({vecs[v].name, "_reset_outs"},
                {Rdata_valid, receive_data, mem_we, mem_addr, mem_wdata, Receive_fin, frame_err, cksum_err}, '0);
            for (int k = 0; k < 4; k++) send_byte(1'b0, 8'(vecs[v].len >> (8 * k)), 1'b1);
            for (int i = 0; i < vecs[v].len; i++) send_byte(1'b0, vecs[v].pay[i], i != vecs[v].bad_idx);
            send_byte(1'b0, vecs[v].ck, 1'b1);
            wait_fin({vecs[v].name, "_fin"}, 64);
            tick(20);
            chk_writes(vecs[v].name, vecs[v].nwr, vecs[v].w0, vecs[v].w1);
            chk({vecs[v].name, "_cksum_err"}, cksum_err, vecs[v].ck_err);
            chk({vecs[v].name, "_frame_err"}, frame_err, vecs[v].fr_err);
            chk({vecs[v].name, "_fin_held"}, Receive_fin, 1'b1);
        end

        // Short low pulse on an idle line must not produce a byte.
        do_reset();
        rxd = 1'b0;
        tick(6);
        rxd = 1'b1;
        tick(40);
        chk("glitch_no_valid", rv_cnt, 0);
        send_byte(1'b0, 8'h5A, 1'b1);
        tick(4);
        chk("glitch_next_valid", rv_cnt, 1);
        chk("glitch_next_data", receive_data, 8'h5A);
        chk("glitch_frame_err", frame_err, 1'b0);

        // Reset in the middle of the payload, then a clean frame.
        do_reset();
        send_byte(1'b0, 8'h04, 1'b1);
        for (int k = 0; k < 3; k++) send_byte(1'b0, 8'h00, 1'b1);
        send_byte(1'b0, 8'h11, 1'b1);
        send_byte(1'b0, 8'h22, 1'b1);
        rxd = 1'b0;
        tick(30);
        RST_N = 1'b0;
        rxd   = 1'b1;
        tick(3);
        chk("midrst_outs_zero", {Rdata_valid, receive_data, mem_we, mem_addr, mem_wdata, Receive_fin}, '0);
        RST_N = 1'b1;
        tick(40);
        clear_mon();
        send_byte(1'b0, 8'h04, 1'b1);
        for (int k = 0; k < 3; k++) send_byte(1'b0, 8'h00, 1'b1);
        send_byte(1'b0, 8'h11, 1'b1);
        send_byte(1'b0, 8'h22, 1'b1);
        send_byte(1'b0, 8'h33, 1'b1);
        send_byte(1'b0, 8'h44, 1'b1);
        send_byte(1'b0, 8'hAA, 1'b1);
        wait_fin("midrst_fin", 64);
        tick(10);
        chk_writes("midrst", 1, 32'h44332211, 32'h0);
        chk("midrst_cksum_err", cksum_err, 1'b0);
        chk("midrst_frame_err", frame_err, 1'b0);

        // Without checksum, a zero length finishes right after the last header byte.
        do_reset();
        for (int k = 0; k < 3; k++) send_byte(1'b1, 8'h00, 1'b1);
        tick(2);
        chk("nock_fin_before_hdr", Receive_fin_b, 1'b0);
        send_byte(1'b1, 8'h00, 1'b1);
        tick(4);
        chk("nock_fin", Receive_fin_b, 1'b1);
        chk("nock_fin_seen", fin_cyc_b >= 0, 1'b1);
        chk("nock_fin_timing", fin_cyc_b, rv_cyc_b + 1);
        chk("nock_no_writes", wr_cnt_b, 0);
        chk("nock_cksum_err", cksum_err_b, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
